mpsoc_uart_ahb3_host: RTL and testbench

AHB3 single-transfer master that sits directly upstream of the UART's AHB3-to-APB peripheral bridge and drives its AHB slave port. It converts a simple valid/ready request channel (from a CPU-side sequencer or debug controller) into AHB3 SINGLE/NONSEQ transfers. It returns read data and error status on a valid/ready response channel. Unaligned or oversize requests are rejected locally without any bus activity.

---
 rtl/mpsoc_uart_ahb3_host.sv | 230 +++++++++++++++++++++++
 tb/tb_mpsoc_uart_ahb3_host.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_uart_ahb3_host.sv
// mpsoc_uart_ahb3_host
// Single-transfer AHB3 master in front of the UART AHB3-to-APB bridge.
// It turns a valid/ready request into one SINGLE/NONSEQ transfer and
// returns read data and error status on a valid/ready response channel.
// Unaligned or oversize requests are answered locally with an error and
// never reach the bus.
//
// Handshakes: a channel transfers on a clock edge where valid and ready are
// both high. A source holds its payload stable until that edge. req_ready
// depends only on the FSM state and reset, and never on req_valid.
//
// Optional feature: define MPSOC_UART_AHB3_HOST_TIMEOUT_EN to abandon a
// transfer after TIMEOUT_CYCLES HREADY-low cycles in ADDR or DATA.
module mpsoc_uart_ahb3_host #(
    parameter int HADDR_SIZE     = 32,
    parameter int HDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [HADDR_SIZE-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [HDATA_SIZE-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic                  HRESP,

    output logic [1:0]            dbg_state_o
);

    // Largest legal HSIZE for this data bus (2 for a 32-bit bus).
    localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    hsel_q, hsel_d;
    logic [1:0]              htrans_q, htrans_d;
    logic                    hwrite_q, hwrite_d;
    logic [HADDR_SIZE-1:0]   haddr_q, haddr_d;
    logic [2:0]              hsize_q, hsize_d;
    logic [HDATA_SIZE-1:0]   hwdata_q, hwdata_d;
    logic [HDATA_SIZE-1:0]   wdata_hold_q, wdata_hold_d;
    logic [HDATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    req_ok;
    logic                    timeout;

`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] wait_q, wait_d;

    // The HREADY-low cycle that brings the count to TIMEOUT_CYCLES ends the transfer.
    assign timeout = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !HREADY &&
                     (wait_q == TCW'(TIMEOUT_CYCLES - 1));

    // Wait-state counter register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // Local legality check: size must fit the bus and the address must be naturally aligned.
    always_comb begin
        req_ok = (req_size <= 3'(MAX_SIZE));
        for (int i = 0; i < MAX_SIZE; i++) begin
            if ((3'(i) < req_size) && req_addr[i]) req_ok = 1'b0;
        end
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d      = state_q;
        hsel_d       = hsel_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        haddr_d      = haddr_q;
        hsize_d      = hsize_q;
        hwdata_d     = hwdata_q;
        wdata_hold_d = wdata_hold_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
        wait_d       = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        haddr_d      = req_addr;
                        hwrite_d     = req_write;
                        hsize_d      = req_size;
                        hsel_d       = 1'b1;
                        htrans_d     = TRANS_NONSEQ;
                        wdata_hold_d = req_wdata;
                        state_d      = ST_ADDR;
`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
                        wait_d       = '0;
`endif
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (timeout) begin
                    hsel_d      = 1'b0;
                    htrans_d    = TRANS_IDLE;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else if (HREADY) begin
                    hsel_d   = 1'b0;
                    htrans_d = TRANS_IDLE;
                    hwdata_d = wdata_hold_q;
                    state_d  = ST_DATA;
`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
                    wait_d   = '0;
`endif
                end else begin
`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            ST_DATA: begin
                if (timeout) begin
                    hsel_d      = 1'b0;
                    htrans_d    = TRANS_IDLE;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else if (HREADY) begin
                    // Only the HRESP seen with HREADY high counts; the first ERROR cycle is a wait.
                    rsp_rdata_d = hwrite_q ? '0 : HRDATA;
                    rsp_err_d   = HRESP;
                    state_d     = ST_RESP;
                end else begin
`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bus/response registers; reset drops everything immediately.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            hsel_q       <= 1'b0;
            htrans_q     <= TRANS_IDLE;
            hwrite_q     <= 1'b0;
            haddr_q      <= '0;
            hsize_q      <= 3'd0;
            hwdata_q     <= '0;
            wdata_hold_q <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hsel_q       <= hsel_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            haddr_q      <= haddr_d;
            hsize_q      <= hsize_d;
            hwdata_q     <= hwdata_d;
            wdata_hold_q <= wdata_hold_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) && !HRESET;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

    assign HSEL        = hsel_q;
    assign HADDR       = haddr_q;
    assign HWDATA      = hwdata_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HBURST      = 3'b000;
    assign HPROT       = 4'b0001;
    assign HTRANS      = htrans_q;
    assign HMASTLOCK   = 1'b0;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mpsoc_uart_ahb3_host.sv
// Directed bench for mpsoc_uart_ahb3_host: reset values, zero-wait write,
// read with data-phase wait states, local rejects, two-cycle ERROR response,
// asynchronous reset mid-transfer and the wait-state timeout
// (MPSOC_UART_AHB3_HOST_TIMEOUT_EN, bench uses TIMEOUT_CYCLES=8).
module tb_mpsoc_uart_ahb3_host;

    logic        HCLK;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HRESP;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    mpsoc_uart_ahb3_host #(
        .HADDR_SIZE     (32),
        .HDATA_SIZE     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HTRANS      (HTRANS),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // One comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Present a request (accepted on the next edge if req_ready)
    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
    endtask

    initial begin
        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'd0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        HRDATA    = 32'h0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        // ---------------- reset values ----------------
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_hsel",      32'(HSEL),      32'h0);
        chk("rst_htrans",    32'(HTRANS),    32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_haddr",     HADDR,          32'h0);
        chk("rst_hwdata",    HWDATA,         32'h0);
        chk("rst_hburst",    32'(HBURST),    32'h0);
        chk("rst_hprot",     32'(HPROT),     32'h1);
        chk("rst_state",     32'(dbg_state_o), 32'h0);
        tick();
        tick();
        HRESET = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'h1);

        // ---------------- zero-wait write ----------------
        drive_req(1'b1, 32'h0000_0000, 3'd2, 32'h0000_00A5);
        HRDATA = 32'hDEAD_BEEF;
        tick();                                   // edge 0: handshake
        req_valid = 1'b0;
        chk("wr_htrans_nonseq", 32'(HTRANS), 32'h2);
        chk("wr_hsel",          32'(HSEL),   32'h1);
        chk("wr_hwrite",        32'(HWRITE), 32'h1);
        chk("wr_hsize",         32'(HSIZE),  32'h2);
        chk("wr_req_ready_busy", 32'(req_ready), 32'h0);
        tick();                                   // edge 1: data phase
        chk("wr_htrans_idle", 32'(HTRANS), 32'h0);
        chk("wr_hsel_drop",   32'(HSEL),   32'h0);
        chk("wr_hwdata",      HWDATA,      32'h0000_00A5);
        chk("wr_rsp_early",   32'(rsp_valid), 32'h0);
        tick();                                   // edge 2: response
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_err",   32'(rsp_err),   32'h0);
        chk("wr_rsp_rdata", rsp_rdata,      32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_rsp_clear", 32'(rsp_valid), 32'h0);
        chk("wr_back_idle", 32'(req_ready), 32'h1);

        // ---------------- byte read, 2 data-phase wait states ----------------
        drive_req(1'b0, 32'h0000_0014, 3'd0, 32'h0);
        HRDATA = 32'h0;
        tick();                                   // edge 0
        req_valid = 1'b0;
        chk("rd_htrans", 32'(HTRANS), 32'h2);
        chk("rd_haddr",  HADDR,       32'h0000_0014);
        chk("rd_hsize",  32'(HSIZE),  32'h0);
        chk("rd_hwrite", 32'(HWRITE), 32'h0);
        tick();                                   // edge 1 -> DATA
        HREADY = 1'b0;
        tick();                                   // edge 2 wait
        chk("rd_wait1_state", 32'(dbg_state_o), 32'h2);
        chk("rd_wait1_valid", 32'(rsp_valid),   32'h0);
        tick();                                   // edge 3 wait
        chk("rd_wait2_valid", 32'(rsp_valid), 32'h0);
        HREADY = 1'b1;
        HRDATA = 32'h0000_0060;
        tick();                                   // edge 4 -> RESP
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata", rsp_rdata,      32'h0000_0060);
        chk("rd_rsp_err",   32'(rsp_err),   32'h0);
        HRDATA = 32'h0;
        tick();                                   // stalled response holds
        chk("rd_hold_valid", 32'(rsp_valid), 32'h1);
        chk("rd_hold_rdata", rsp_rdata,      32'h0000_0060);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_rsp_clear", 32'(rsp_valid), 32'h0);

        // ---------------- local rejects ----------------
        drive_req(1'b0, 32'h0000_0002, 3'd2, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("rej_unaligned_valid",  32'(rsp_valid), 32'h1);
        chk("rej_unaligned_err",    32'(rsp_err),   32'h1);
        chk("rej_unaligned_rdata",  rsp_rdata,      32'h0);
        chk("rej_unaligned_htrans", 32'(HTRANS),    32'h0);
        chk("rej_unaligned_hsel",   32'(HSEL),      32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        drive_req(1'b1, 32'h0000_0000, 3'd3, 32'h1111_1111);
        tick();
        req_valid = 1'b0;
        chk("rej_oversize_valid",  32'(rsp_valid), 32'h1);
        chk("rej_oversize_err",    32'(rsp_err),   32'h1);
        chk("rej_oversize_htrans", 32'(HTRANS),    32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rej_back_idle", 32'(req_ready), 32'h1);

        // ---------------- two-cycle ERROR on a write ----------------
        drive_req(1'b1, 32'h0000_0008, 3'd2, 32'h1234_5678);
        tick();                                   // edge 0
        req_valid = 1'b0;
        tick();                                   // edge 1 -> DATA
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();                                   // first ERROR cycle is a wait
        chk("err_wait_valid", 32'(rsp_valid), 32'h0);
        HREADY = 1'b1;
        tick();                                   // second ERROR cycle captured
        HRESP = 1'b0;
        chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("err_rsp_err",   32'(rsp_err),   32'h1);
        chk("err_rsp_rdata", rsp_rdata,      32'h0);
        drive_req(1'b0, 32'h0000_0004, 3'd2, 32'h55AA_55AA);
        tick();                                   // request blocked while response pending
        chk("err_blocked_ready",  32'(req_ready), 32'h0);
        chk("err_blocked_htrans", 32'(HTRANS),    32'h0);
        chk("err_held_valid",     32'(rsp_valid), 32'h1);
        chk("err_held_err",       32'(rsp_err),   32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("err_released_ready", 32'(req_ready), 32'h1);
        tick();                                   // pending request now accepted
        req_valid = 1'b0;
        chk("next_htrans", 32'(HTRANS), 32'h2);
        chk("next_haddr",  HADDR,       32'h0000_0004);

        // ---------------- asynchronous reset during DATA ----------------
        tick();                                   // -> DATA
        chk("rst_mid_state_data", 32'(dbg_state_o), 32'h2);
        HRESET = 1'b1;
        #1;
        chk("rst_mid_hsel",      32'(HSEL),        32'h0);
        chk("rst_mid_htrans",    32'(HTRANS),      32'h0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid),   32'h0);
        chk("rst_mid_req_ready", 32'(req_ready),   32'h0);
        chk("rst_mid_haddr",     HADDR,            32'h0);
        chk("rst_mid_hwdata",    HWDATA,           32'h0);
        chk("rst_mid_state",     32'(dbg_state_o), 32'h0);
        tick();
        HRESET = 1'b0;
        drive_req(1'b0, 32'h0000_000C, 3'd2, 32'h0);
        HRDATA = 32'hCAFE_F00D;
        tick();
        req_valid = 1'b0;
        chk("post_rst_htrans", 32'(HTRANS), 32'h2);
        tick();
        tick();
        chk("post_rst_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_rdata", rsp_rdata,      32'hCAFE_F00D);
        chk("post_rst_err",   32'(rsp_err),   32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---------------- HREADY stuck low ----------------
        drive_req(1'b0, 32'h0000_0010, 3'd2, 32'h0);
        HREADY = 1'b0;
        HRDATA = 32'h0BAD_F00D;
        tick();                                   // edge 0 -> ADDR
        req_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();                               // edges 1..7
            chk("stall_no_rsp", 32'(rsp_valid), 32'h0);
        end
        tick();                                   // edge 8
`ifdef MPSOC_UART_AHB3_HOST_TIMEOUT_EN
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("tmo_rsp_err",   32'(rsp_err),   32'h1);
        chk("tmo_rsp_rdata", rsp_rdata,      32'h0);
        chk("tmo_htrans",    32'(HTRANS),    32'h0);
        chk("tmo_hsel",      32'(HSEL),      32'h0);
        HREADY    = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tmo_back_idle", 32'(req_ready), 32'h1);
`else
        chk("notmo_no_rsp", 32'(rsp_valid), 32'h0);
        chk("notmo_htrans", 32'(HTRANS),    32'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("notmo_still_waiting", 32'(rsp_valid), 32'h0);
        end
        HREADY = 1'b1;
        tick();                                   // -> DATA
        tick();                                   // -> RESP
        chk("notmo_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("notmo_rsp_rdata", rsp_rdata,      32'h0BAD_F00D);
        chk("notmo_rsp_err",   32'(rsp_err),   32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("notmo_back_idle", 32'(req_ready), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
